// File: rtl/gpio_irq_controller.sv
// GPIO block: per-pin direction, atomic set/clear/toggle, debounced inputs and
// edge/level interrupts, accessed over the io_read/io_write/io_ready register bus.
module gpio_irq_controller #(
    parameter int unsigned GPIO_NUMS = 8,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DB_W      = 8
) (
    input  logic                 gpio_clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      io_addr,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic [XLEN-1:0]      io_wdata,
    output logic [XLEN-1:0]      io_rdata,
    output logic                 io_ready,
    inout  wire  [GPIO_NUMS-1:0] gpio_values,
    output logic                 gpio_int
);
    localparam int unsigned N      = GPIO_NUMS;
    localparam int unsigned ADDR_W = 6;

    localparam logic [ADDR_W-1:0] A_DIR  = 6'h00;
    localparam logic [ADDR_W-1:0] A_OUT  = 6'h04;
    localparam logic [ADDR_W-1:0] A_IN   = 6'h08;
    localparam logic [ADDR_W-1:0] A_STAT = 6'h0C;
    localparam logic [ADDR_W-1:0] A_EN   = 6'h10;
    localparam logic [ADDR_W-1:0] A_TYPE = 6'h14;
    localparam logic [ADDR_W-1:0] A_POL  = 6'h18;
    localparam logic [ADDR_W-1:0] A_BOTH = 6'h1C;
    localparam logic [ADDR_W-1:0] A_SET  = 6'h20;
    localparam logic [ADDR_W-1:0] A_CLR  = 6'h24;
    localparam logic [ADDR_W-1:0] A_TGL  = 6'h28;
    localparam logic [ADDR_W-1:0] A_DB   = 6'h2C;

    typedef enum logic {ST_IDLE, ST_BUSY} bus_state_t;

    bus_state_t        state_q, state_d;
    logic              accept_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] addr_c;
    logic [N-1:0]      wd_c;
    logic [XLEN-1:0]   rd_c;

    logic [N-1:0]      dir_q, out_q, en_q, type_q, pol_q, both_q, status_q;
    logic [N-1:0]      en_d, status_d, w1c_c;
    logic [DB_W-1:0]   db_q;

    logic [N-1:0]      sync1_q, sync2_q, stable_q, stable_d_q;
    logic [DB_W-1:0]   cnt_q [N];
    logic [N-1:0]      rise_c, fall_c, edge_ev_c, lvl_ev_c, ev_c;

    logic              unused_bits;
    assign unused_bits = ^{io_addr[XLEN-1:ADDR_W], io_wdata};

    assign addr_c  = io_addr[ADDR_W-1:0];
    assign wd_c    = io_wdata[N-1:0];
    assign wr_en_c = accept_c & io_write;

    // One access per request assertion: busy holds until both requests drop.
    always_ff @(posedge gpio_clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_read || io_write) begin
                    accept_c = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!io_read && !io_write) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_c = '0;
        case (addr_c)
            A_DIR:   rd_c = XLEN'(dir_q);
            A_OUT:   rd_c = XLEN'(out_q);
            A_IN:    rd_c = XLEN'(stable_q);
            A_STAT:  rd_c = XLEN'(status_q);
            A_EN:    rd_c = XLEN'(en_q);
            A_TYPE:  rd_c = XLEN'(type_q);
            A_POL:   rd_c = XLEN'(pol_q);
            A_BOTH:  rd_c = XLEN'(both_q);
            A_DB:    rd_c = XLEN'(db_q);
            default: rd_c = '0;
        endcase
    end

    // Interrupt detection on the debounced value; output pins never raise events.
    assign rise_c    = stable_q & ~stable_d_q;
    assign fall_c    = ~stable_q & stable_d_q;
    assign edge_ev_c = (both_q & (rise_c | fall_c)) |
                       (~both_q & ((pol_q & fall_c) | (~pol_q & rise_c)));
    assign lvl_ev_c  = ~(stable_q ^ pol_q);
    assign ev_c      = ~dir_q & ((type_q & lvl_ev_c) | (~type_q & edge_ev_c));

    assign w1c_c    = (wr_en_c && addr_c == A_STAT) ? wd_c : '0;
    assign status_d = (status_q & ~w1c_c) | ev_c;
    assign en_d     = (wr_en_c && addr_c == A_EN) ? wd_c : en_q;

    always_ff @(posedge gpio_clk or negedge rst) begin
        if (!rst) begin
            dir_q    <= '0;
            out_q    <= '0;
            en_q     <= '0;
            type_q   <= '0;
            pol_q    <= '0;
            both_q   <= '0;
            status_q <= '0;
            db_q     <= '0;
            io_rdata <= '0;
            io_ready <= 1'b0;
            gpio_int <= 1'b0;
        end else begin
            io_ready <= accept_c;
            if (accept_c) io_rdata <= io_write ? '0 : rd_c;
            status_q <= status_d;
            en_q     <= en_d;
            gpio_int <= |(status_d & en_d);
            if (wr_en_c) begin
                case (addr_c)
                    A_DIR:   dir_q  <= wd_c;
                    A_OUT:   out_q  <= wd_c;
                    A_TYPE:  type_q <= wd_c;
                    A_POL:   pol_q  <= wd_c;
                    A_BOTH:  both_q <= wd_c;
                    A_SET:   out_q  <= out_q | wd_c;
                    A_CLR:   out_q  <= out_q & ~wd_c;
                    A_TGL:   out_q  <= out_q ^ wd_c;
                    A_DB:    db_q   <= io_wdata[DB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Two-flop synchroniser followed by a per-pin saturating debounce counter.
    always_ff @(posedge gpio_clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            stable_d_q <= '0;
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= gpio_values;
            sync2_q    <= sync1_q;
            stable_d_q <= stable_q;
            for (int i = 0; i < int'(N); i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= db_q) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_pin
        assign gpio_values[g] = dir_q[g] ? out_q[g] : 1'bz;
    end

endmodule
